// File: rtl/player_status_fsm_pkg.sv
// Shared definitions for the player status tracker and its timed helpers:
// state encodings, default durations and the millisecond timer width.
package player_status_fsm_pkg;

  localparam int TIMER_W = 16;

  localparam int unsigned DEF_TICK_DIV  = 100000;
  localparam int unsigned DEF_SPEED_MS  = 5000;
  localparam int unsigned DEF_SHIELD_MS = 8000;
  localparam int unsigned DEF_GRACE_MS  = 1000;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_RUN   = 2'b01,
    ST_GRACE = 2'b10,
    ST_OVER  = 2'b11
  } state_t;

  // Saturating millisecond decrement shared by all down-counters.
  function automatic logic [TIMER_W-1:0] ms_dec(input logic [TIMER_W-1:0] v);
    return (v == '0) ? v : v - TIMER_W'(1);
  endfunction

endpackage

// File: rtl/ms_tick_gen.sv
// Millisecond prescaler: counts 0..TICK_DIV-1 while enabled and emits a
// one-cycle tick on the wrap back to 0. Clear forces the count to 0.
module ms_tick_gen #(
  parameter int unsigned TICK_DIV = 100000
) (
  input  logic clock_100mhz,
  input  logic reset,
  input  logic enable,
  input  logic clear,
  output logic tick
);

  localparam int CW = $clog2(TICK_DIV + 1);
  localparam logic [CW-1:0] LAST = CW'(TICK_DIV - 1);

  logic [CW-1:0] count;

  always_ff @(posedge clock_100mhz) begin
    if (reset || clear) begin
      count <= '0;
    end else if (enable) begin
      count <= (count == LAST) ? '0 : count + CW'(1);
    end
  end

  assign tick = enable && (count == LAST);

endmodule

// File: rtl/player_status_fsm.sv
// Player status tracker: edge-detects collision and pickup flags and owns the
// speed boost, shield, post-hit grace window and game-over state.
//
// state    | meaning
// ST_IDLE  | no round running, everything cleared
// ST_RUN   | round running, collisions are live
// ST_GRACE | shield absorbed a hit, collisions ignored until grace expires
// ST_OVER  | unshielded hit, game_over held until game_active drops
module player_status_fsm
  import player_status_fsm_pkg::*;
#(
  parameter int unsigned TICK_DIV  = DEF_TICK_DIV,
  parameter int unsigned SPEED_MS  = DEF_SPEED_MS,
  parameter int unsigned SHIELD_MS = DEF_SHIELD_MS,
  parameter int unsigned GRACE_MS  = DEF_GRACE_MS
) (
  input  logic               clock_100mhz,
  input  logic               reset,
  input  logic               game_active,
  input  logic               is_collision,
  input  logic               is_speed_powerup_collision,
  input  logic               is_shield_powerup_collision,
  output logic               speed_active,
  output logic               shield_active,
  output logic               invulnerable,
  output logic               shield_hit,
  output logic               game_over,
  output logic [TIMER_W-1:0] speed_ms_left,
  output logic [TIMER_W-1:0] shield_ms_left
);

  localparam logic [TIMER_W-1:0] SPEED_LOAD  = TIMER_W'(SPEED_MS);
  localparam logic [TIMER_W-1:0] SHIELD_LOAD = TIMER_W'(SHIELD_MS);
  localparam logic [TIMER_W-1:0] GRACE_LOAD  = TIMER_W'(GRACE_MS);

  state_t state, state_nxt;

  logic prev_coll, prev_speed, prev_shield;
  logic coll_edge, speed_edge, shield_edge;
  logic [TIMER_W-1:0] speed_cnt, shield_cnt, grace_cnt;
  logic hit_pulse;
  logic live, absorb, ms_tick, tick_clear;

  assign coll_edge   = is_collision && !prev_coll;
  assign speed_edge  = is_speed_powerup_collision && !prev_speed;
  assign shield_edge = is_shield_powerup_collision && !prev_shield;

  assign live       = (state == ST_RUN) || (state == ST_GRACE);
  assign tick_clear = (state == ST_IDLE) || !game_active;
  // A shield picked up in the same cycle as the hit still counts as armed.
  assign absorb = (state == ST_RUN) && game_active && coll_edge &&
                  ((shield_cnt != '0) || shield_edge);

  ms_tick_gen #(.TICK_DIV(TICK_DIV)) u_ms_tick (
    .clock_100mhz (clock_100mhz),
    .reset        (reset),
    .enable       (live),
    .clear        (tick_clear),
    .tick         (ms_tick)
  );

  always_ff @(posedge clock_100mhz) begin
    if (reset) state <= ST_IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    if (!game_active) begin
      state_nxt = ST_IDLE;
    end else begin
      case (state)
        ST_IDLE:  state_nxt = ST_RUN;
        ST_RUN:   if (coll_edge) state_nxt = absorb ? ST_GRACE : ST_OVER;
        ST_GRACE: if (ms_tick && (grace_cnt <= TIMER_W'(1))) state_nxt = ST_RUN;
        ST_OVER:  state_nxt = ST_OVER;
        default:  state_nxt = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clock_100mhz) begin
    if (reset || !game_active || (state == ST_IDLE)) begin
      prev_coll   <= 1'b0;
      prev_speed  <= 1'b0;
      prev_shield <= 1'b0;
      speed_cnt   <= '0;
      shield_cnt  <= '0;
      grace_cnt   <= '0;
      hit_pulse   <= 1'b0;
    end else begin
      prev_coll   <= is_collision;
      prev_speed  <= is_speed_powerup_collision;
      prev_shield <= is_shield_powerup_collision;
      hit_pulse   <= absorb;
      if ((state == ST_OVER) || ((state == ST_RUN) && coll_edge && !absorb)) begin
        speed_cnt  <= '0;
        shield_cnt <= '0;
        grace_cnt  <= '0;
      end else begin
        if (speed_edge)   speed_cnt <= SPEED_LOAD;
        else if (ms_tick) speed_cnt <= ms_dec(speed_cnt);

        if (absorb)           shield_cnt <= '0;
        else if (shield_edge) shield_cnt <= SHIELD_LOAD;
        else if (ms_tick)     shield_cnt <= ms_dec(shield_cnt);

        if (absorb)                                grace_cnt <= GRACE_LOAD;
        else if ((state == ST_GRACE) && ms_tick)   grace_cnt <= ms_dec(grace_cnt);
      end
    end
  end

  always_comb begin
    speed_active   = (speed_cnt != '0);
    shield_active  = (shield_cnt != '0);
    invulnerable   = (state == ST_GRACE);
    game_over      = (state == ST_OVER);
    shield_hit     = hit_pulse;
    speed_ms_left  = speed_cnt;
    shield_ms_left = shield_cnt;
  end

endmodule
